// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch resolution unit: funct3 branch encodings,
// controller state type and the branch-condition evaluator.
package branch_ctrl_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   // Comparator BrLT is stale when operands are equal, so it is masked by BrEq.
   function automatic logic branch_taken(input logic [2:0] funct3,
                                         input logic       eq,
                                         input logic       lt_raw);
      logic lt;
      lt = lt_raw & ~eq;
      case (funct3)
         F3_BEQ:           branch_taken = eq;
         F3_BNE:           branch_taken = ~eq;
         F3_BLT, F3_BLTU:  branch_taken = lt;
         F3_BGE, F3_BGEU:  branch_taken = ~lt;
         default:          branch_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters with a combinational read
// port for fetch and a single update port from the resolving branch.
module branch_bht #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_taken_o,
   input  logic             upd_en_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i
);

   logic [1:0] ctr_q [ENTRIES];
   logic [1:0] upd_ctr_d;

   always_comb begin
      upd_ctr_d = ctr_q[upd_idx_i];
      if (upd_taken_i && ctr_q[upd_idx_i] != 2'b11) begin
         upd_ctr_d = ctr_q[upd_idx_i] + 2'b01;
      end else if (!upd_taken_i && ctr_q[upd_idx_i] != 2'b00) begin
         upd_ctr_d = ctr_q[upd_idx_i] - 2'b01;
      end
   end

   // Counters start weakly not-taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
      end else if (upd_en_i) begin
         ctr_q[upd_idx_i] <= upd_ctr_d;
      end
   end

   assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution, mispredict redirect and wrong-path flush control.
// Define BRANCH_CTRL_BHT_EN to add a dynamic predictor; otherwise static not-taken.
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int BHT_ENTRIES  = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic            ex_is_jump,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic            BrEq,
   input  logic            BrLT,
   output logic            BrUn,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_pred_taken,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush
);

   localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              redirect_q;
   logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
   logic              resolve, taken, mispredict, cnt_done;

   assign BrUn       = ex_funct3[1];
   assign resolve    = ex_valid & (ex_is_branch | ex_is_jump) & (state_q == ST_IDLE);
   assign taken      = ex_is_jump | branch_taken(ex_funct3, BrEq, BrLT);
   assign mispredict = resolve & (taken != ex_pred_taken);
   assign cnt_done   = (cnt_q == CNT_W'(FLUSH_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         ST_IDLE:  if (mispredict) state_d = ST_FLUSH;
         ST_FLUSH: begin
            if (cnt_done) state_d = ST_IDLE;
            else          cnt_d   = cnt_q + 1'b1;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      flush = (state_q == ST_FLUSH);
   end

   assign redirect_pc_d = !mispredict ? redirect_pc_q
                        : taken       ? ex_target
                        :               ex_pc + XLEN'(4);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         redirect_q    <= mispredict;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;

`ifdef BRANCH_CTRL_BHT_EN
   logic unused_if_pc;

   branch_bht #(
      .ENTRIES (BHT_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_bht (
      .clk         (clk),
      .rst         (rst),
      .rd_idx_i    (if_pc[IDX_W+1:2]),
      .rd_taken_o  (if_pred_taken),
      .upd_en_i    (resolve & ex_is_branch & ~ex_is_jump),
      .upd_idx_i   (ex_pc[IDX_W+1:2]),
      .upd_taken_i (taken)
   );

   assign unused_if_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};
`else
   logic unused_if_pc;

   assign if_pred_taken = 1'b0;
   assign unused_if_pc  = ^if_pc;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized
// traffic compared against a countdown/array reference model.
module tb_branch_ctrl;

   localparam int XLEN = 32;
   localparam int FC   = 2;
   localparam int NB   = 16;
`ifdef BRANCH_CTRL_BHT_EN
   localparam bit BHT = 1'b1;
`else
   localparam bit BHT = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            ex_valid, ex_is_branch, ex_is_jump;
   logic [2:0]      ex_funct3;
   logic [XLEN-1:0] ex_pc, ex_target, if_pc, redirect_pc;
   logic            ex_pred_taken, BrEq, BrLT, BrUn, if_pred_taken, redirect, flush;

   int total = 0;
   int bad   = 0;

   int          m_flush_left;
   logic        m_redirect;
   logic [31:0] m_rpc;
   int          m_bht [NB];

   branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .BHT_ENTRIES(NB)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
      .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
      .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .BrEq(BrEq), .BrLT(BrLT),
      .BrUn(BrUn), .if_pc(if_pc), .if_pred_taken(if_pred_taken), .redirect(redirect),
      .redirect_pc(redirect_pc), .flush(flush)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   function automatic bit ref_taken(input logic [2:0] f3, input logic eq, input logic lt_raw);
      bit lt;
      lt = lt_raw && !eq;
      case (f3)
         3'd0:       return eq;
         3'd1:       return !eq;
         3'd4, 3'd6: return lt;
         3'd5, 3'd7: return !lt;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic bit ref_pred(input logic [31:0] pc);
      if (!BHT) return 1'b0;
      return m_bht[int'((pc >> 2) % NB)] >= 2;
   endfunction

   task automatic model_reset();
      m_flush_left = 0;
      m_redirect   = 1'b0;
      m_rpc        = '0;
      for (int i = 0; i < NB; i++) m_bht[i] = 1;
   endtask

   // Advance one clock edge and update the reference model from the inputs seen at that edge.
   task automatic model_clock();
      bit resolve, tk;
      int idx;
      @(posedge clk);
      resolve = ex_valid && (ex_is_branch || ex_is_jump) && (m_flush_left == 0);
      tk      = ex_is_jump ? 1'b1 : ref_taken(ex_funct3, BrEq, BrLT);
      if (BHT && resolve && ex_is_branch && !ex_is_jump) begin
         idx = int'((ex_pc >> 2) % NB);
         if (tk && m_bht[idx] < 3) m_bht[idx]++;
         else if (!tk && m_bht[idx] > 0) m_bht[idx]--;
      end
      if (m_flush_left > 0) m_flush_left--;
      if (resolve && (tk != ex_pred_taken)) begin
         m_redirect   = 1'b1;
         m_rpc        = tk ? ex_target : ex_pc + 32'd4;
         m_flush_left = FC;
      end else begin
         m_redirect = 1'b0;
      end
      #1;
   endtask

   task automatic drive(input bit v, input bit br, input bit jmp, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input bit pred, input bit eq, input bit lt);
      ex_valid = v; ex_is_branch = br; ex_is_jump = jmp; ex_funct3 = f3;
      ex_pc = pc; ex_target = tgt; ex_pred_taken = pred; BrEq = eq; BrLT = lt;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      idle();
      if_pc = 32'h40;
      repeat (2) @(posedge clk);
      #1;
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%0b exp=0", redirect); end
      total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redirect_pc got=%h exp=00000000", redirect_pc); end
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b exp=0", flush); end
      total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred got=%0b exp=0", if_pred_taken); end
      rst = 1'b0;
      model_reset();
      $display("txn reset released");
   endtask

   task automatic test_beq_mispredict();
      drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h84, 32'h100, 1'b0, 1'b1, 1'b1);
      #1;
      total++; if (BrUn !== 1'b0) begin bad++; $display("FAIL beq_brun got=%0b exp=0", BrUn); end
      model_clock();
      idle();
      total++; if (redirect !== 1'b1) begin bad++; $display("FAIL beq_redirect got=%0b exp=1", redirect); end
      total++; if (redirect_pc !== 32'h100) begin bad++; $display("FAIL beq_redirect_pc got=%h exp=00000100", redirect_pc); end
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL beq_flush1 got=%0b exp=1", flush); end
      model_clock();
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL beq_redirect_pulse got=%0b exp=0", redirect); end
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL beq_flush2 got=%0b exp=1", flush); end
      model_clock();
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL beq_flush_end got=%0b exp=0", flush); end
      $display("txn beq mispredict pc=00000084 target=00000100");
   endtask

   task automatic test_bltu_correct();
      drive(1'b1, 1'b1, 1'b0, 3'b110, 32'h88, 32'h200, 1'b0, 1'b0, 1'b0);
      #1;
      total++; if (BrUn !== 1'b1) begin bad++; $display("FAIL bltu_brun got=%0b exp=1", BrUn); end
      model_clock();
      idle();
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL bltu_redirect got=%0b exp=0", redirect); end
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL bltu_flush got=%0b exp=0", flush); end
      $display("txn bltu correctly predicted not-taken");
   endtask

   task automatic test_pc_wrap();
      drive(1'b1, 1'b1, 1'b0, 3'b001, 32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b1, 1'b0);
      model_clock();
      idle();
      total++; if (redirect !== 1'b1) begin bad++; $display("FAIL wrap_redirect got=%0b exp=1", redirect); end
      total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL wrap_redirect_pc got=%h exp=00000000", redirect_pc); end
      repeat (FC) model_clock();
      $display("txn bne not-taken wrap pc=fffffffc");
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h8C, 32'h200, 1'b0, 1'b1, 1'b0);
      model_clock();
      total++; if (redirect !== 1'b1 || redirect_pc !== 32'h200) begin bad++; $display("FAIL b2b_first got=%0b/%h exp=1/00000200", redirect, redirect_pc); end
      drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h90, 32'h300, 1'b0, 1'b0, 1'b0);
      model_clock();
      idle();
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL b2b_second_ignored got=%0b exp=0", redirect); end
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL b2b_flush got=%0b exp=1", flush); end
      model_clock();
      total++; if (flush !== 1'b0 || redirect !== 1'b0) begin bad++; $display("FAIL b2b_end got=%0b/%0b exp=0/0", flush, redirect); end
      $display("txn back-to-back mispredicts, second dropped");
   endtask

   task automatic test_bht();
      if_pc = 32'h40;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0);
         model_clock();
      end
      idle();
      #1;
      total++; if (if_pred_taken !== BHT) begin bad++; $display("FAIL bht_after_taken got=%0b exp=%0b", if_pred_taken, BHT); end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h40, 32'h80, 1'b0, 1'b0, 1'b0);
         model_clock();
      end
      idle();
      #1;
      total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL bht_after_not_taken got=%0b exp=0", if_pred_taken); end
      total++; if (redirect !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL bht_no_redirect got=%0b/%0b exp=0/0", redirect, flush); end
      $display("txn bht training at pc=00000040");
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic [31:0] pc, tgt;
      int          kind;
      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 2);
         f3   = 3'($urandom_range(0, 7));
         pc   = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 31)) << 2 : ($urandom() & 32'hFFFF_FFFC);
         tgt  = $urandom() & 32'hFFFF_FFFE;
         drive($urandom_range(0, 3) != 0, kind == 0, kind == 1, f3, pc, tgt,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if_pc = 32'($urandom_range(0, 31)) << 2;
         #1;
         total++; if (BrUn !== f3[1]) begin bad++; $display("FAIL rnd_brun n=%0d got=%0b exp=%0b", n, BrUn, f3[1]); end
         total++; if (if_pred_taken !== ref_pred(if_pc)) begin bad++; $display("FAIL rnd_pred n=%0d got=%0b exp=%0b", n, if_pred_taken, ref_pred(if_pc)); end
         model_clock();
         total++; if (redirect !== m_redirect) begin bad++; $display("FAIL rnd_redirect n=%0d got=%0b exp=%0b", n, redirect, m_redirect); end
         total++; if (flush !== (m_flush_left > 0)) begin bad++; $display("FAIL rnd_flush n=%0d got=%0b exp=%0b", n, flush, m_flush_left > 0); end
         if (m_redirect) begin
            total++; if (redirect_pc !== m_rpc) begin bad++; $display("FAIL rnd_redirect_pc n=%0d got=%h exp=%h", n, redirect_pc, m_rpc); end
            $display("txn rnd n=%0d redirect to %h", n, m_rpc);
         end
      end
      idle();
   endtask

   task automatic test_reset_mid_flush();
      idle();
      for (int i = 0; i < FC + 1 && m_flush_left > 0; i++) model_clock();
      drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h500, 32'h900, 1'b0, 1'b0, 1'b0);
      model_clock();
      idle();
      total++; if (flush !== 1'b1 || redirect !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%0b/%0b exp=1/1", flush, redirect); end
      rst = 1'b1;
      #1;
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL rstmid_flush got=%0b exp=0", flush); end
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL rstmid_redirect got=%0b exp=0", redirect); end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      model_clock();
      total++; if (flush !== 1'b0 || redirect !== 1'b0) begin bad++; $display("FAIL rstmid_after got=%0b/%0b exp=0/0", flush, redirect); end
      drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h600, 32'hA00, 1'b0, 1'b0, 1'b0);
      model_clock();
      idle();
      total++; if (redirect !== 1'b1 || redirect_pc !== 32'hA00) begin bad++; $display("FAIL rstmid_idle_resolve got=%0b/%h exp=1/00000a00", redirect, redirect_pc); end
      repeat (FC) model_clock();
      $display("txn reset during flush");
   endtask

   initial begin
      test_reset();
      test_bht();
      test_beq_mispredict();
      test_bltu_correct();
      test_pc_wrap();
      test_back_to_back();
      test_random();
      test_reset_mid_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
